sha256_block_seq: RTL



---
 rtl/sha256_block_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sha256_block_seq.sv
// SHA-256 compression sequencer: one combinational round stepped 64 times over a
// 512-bit block, with on-the-fly message schedule, constant ROM and feed-forward add.

module sha256_round (
    input  logic [255:0] state_in,
    input  logic [31:0]  w,
    input  logic [31:0]  k,
    output logic [255:0] state_out
);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] big_sigma0, big_sigma1, ch, maj, t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;

    assign big_sigma0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    assign big_sigma1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    assign ch         = (e & f) ^ (~e & g);
    assign maj        = (a & b) ^ (a & c) ^ (b & c);
    assign t1         = h + big_sigma1 + ch + k + w;
    assign t2         = big_sigma0 + maj;

    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

module sha256_block_seq #(
    parameter int ROUNDS = 64
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        MSG_WE,
    input  logic [3:0]  MSG_IDX,
    input  logic [31:0] MSG_WDATA,
    input  logic        INIT,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    input  logic [2:0]  HASH_SEL,
    output logic [31:0] HASH_RDATA
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    state_t      state;
    logic [5:0]  t;
    logic [31:0] h_reg  [8];
    logic [31:0] work   [8];
    logic [31:0] buffer [16];
    logic [31:0] window [16];

    logic [255:0] round_in, round_out;
    logic [31:0]  k_word, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] krom(input logic [5:0] idx);
        case (idx)
            6'd0:  return 32'h428a2f98;  6'd1:  return 32'h71374491;
            6'd2:  return 32'hb5c0fbcf;  6'd3:  return 32'he9b5dba5;
            6'd4:  return 32'h3956c25b;  6'd5:  return 32'h59f111f1;
            6'd6:  return 32'h923f82a4;  6'd7:  return 32'hab1c5ed5;
            6'd8:  return 32'hd807aa98;  6'd9:  return 32'h12835b01;
            6'd10: return 32'h243185be;  6'd11: return 32'h550c7dc3;
            6'd12: return 32'h72be5d74;  6'd13: return 32'h80deb1fe;
            6'd14: return 32'h9bdc06a7;  6'd15: return 32'hc19bf174;
            6'd16: return 32'he49b69c1;  6'd17: return 32'hefbe4786;
            6'd18: return 32'h0fc19dc6;  6'd19: return 32'h240ca1cc;
            6'd20: return 32'h2de92c6f;  6'd21: return 32'h4a7484aa;
            6'd22: return 32'h5cb0a9dc;  6'd23: return 32'h76f988da;
            6'd24: return 32'h983e5152;  6'd25: return 32'ha831c66d;
            6'd26: return 32'hb00327c8;  6'd27: return 32'hbf597fc7;
            6'd28: return 32'hc6e00bf3;  6'd29: return 32'hd5a79147;
            6'd30: return 32'h06ca6351;  6'd31: return 32'h14292967;
            6'd32: return 32'h27b70a85;  6'd33: return 32'h2e1b2138;
            6'd34: return 32'h4d2c6dfc;  6'd35: return 32'h53380d13;
            6'd36: return 32'h650a7354;  6'd37: return 32'h766a0abb;
            6'd38: return 32'h81c2c92e;  6'd39: return 32'h92722c85;
            6'd40: return 32'ha2bfe8a1;  6'd41: return 32'ha81a664b;
            6'd42: return 32'hc24b8b70;  6'd43: return 32'hc76c51a3;
            6'd44: return 32'hd192e819;  6'd45: return 32'hd6990624;
            6'd46: return 32'hf40e3585;  6'd47: return 32'h106aa070;
            6'd48: return 32'h19a4c116;  6'd49: return 32'h1e376c08;
            6'd50: return 32'h2748774c;  6'd51: return 32'h34b0bcb5;
            6'd52: return 32'h391c0cb3;  6'd53: return 32'h4ed8aa4a;
            6'd54: return 32'h5b9cca4f;  6'd55: return 32'h682e6ff3;
            6'd56: return 32'h748f82ee;  6'd57: return 32'h78a5636f;
            6'd58: return 32'h84c87814;  6'd59: return 32'h8cc70208;
            6'd60: return 32'h90befffa;  6'd61: return 32'ha4506ceb;
            6'd62: return 32'hbef9a3f7;  default: return 32'hc67178f2;
        endcase
    endfunction

    assign k_word   = krom(t);
    assign round_in = {work[0], work[1], work[2], work[3], work[4], work[5], work[6], work[7]};
    assign w_new    = small_sigma1(window[14]) + window[9] + small_sigma0(window[1]) + window[0];

    sha256_round u_round (
        .state_in  (round_in),
        .w         (window[0]),
        .k         (k_word),
        .state_out (round_out)
    );

    // NOTE: all state, including the buffer and schedule arrays, is reset so a
    // mid-block reset leaves nothing behind; every sequential assignment is non-blocking.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state      <= IDLE;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            HASH_RDATA <= '0;
            t          <= '0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV[i];
                work[i]  <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                buffer[i] <= '0;
                window[i] <= '0;
            end
        end else begin
            DONE <= 1'b0;
            // On the FINAL edge the read port forwards the sum so DONE and the new H coincide.
            HASH_RDATA <= (state == FINAL) ? h_reg[HASH_SEL] + work[HASH_SEL] : h_reg[HASH_SEL];

            case (state)
                IDLE: begin
                    if (MSG_WE)
                        buffer[MSG_IDX] <= MSG_WDATA;
                    if (INIT)
                        for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
                    if (START) begin
                        for (int i = 0; i < 8; i++) work[i] <= INIT ? IV[i] : h_reg[i];
                        for (int i = 0; i < 16; i++) window[i] <= buffer[i];
                        t     <= '0;
                        BUSY  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    for (int i = 0; i < 8; i++) work[i] <= round_out[255 - 32*i -: 32];
                    for (int i = 0; i < 15; i++) window[i] <= window[i + 1];
                    window[15] <= w_new;
                    t          <= t + 6'd1;
                    if (t == LAST_ROUND)
                        state <= FINAL;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + work[i];
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
